// File: rtl/ysyx_23060191_axi_sram_if.sv
// AXI4-Lite bus bundle between the CPU-side initiator and the SRAM responder.
`timescale 1ns/1ps
interface ysyx_23060191_axi_sram_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ysyx_23060191_axi_sram.sv
// AXI4-Lite word SRAM: one outstanding read and one outstanding write,
// independent read/write FSMs with programmable access latency.
`timescale 1ns/1ps
module ysyx_23060191_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WR_LAT      = 1
) (
    input  logic clk,
    input  logic rst,
    ysyx_23060191_axi_sram_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  RD_CNT0 = 4'(RD_LAT - 1);
    localparam logic [3:0]  WR_CNT0 = 4'(WR_LAT - 1);
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  DECERR  = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

    // Borrow out of the 33-bit subtract flags addresses below the base.
    function automatic logic hit(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, ADDR_BASE};
        return !off[32] && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return IDX_W'(off >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    r_state_t    r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    w_state_t    w_state;
    logic [3:0]  w_cnt;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        aw_got;
    logic        w_got;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic aw_done;
    logic w_done;
    logic commit;

    assign ar_hs   = bus.arvalid & arready_q;
    assign r_hs    = rvalid_q & bus.rready;
    assign aw_hs   = bus.awvalid & awready_q;
    assign w_hs    = bus.wvalid & wready_q;
    assign b_hs    = bvalid_q & bus.bready;
    assign aw_done = aw_got | aw_hs;
    assign w_done  = w_got | w_hs;

    assign commit = (w_state == W_WAIT) && (w_cnt == 4'd0)
                    && hit(aw_addr);

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= OKAY;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_addr    <= bus.araddr;
                        r_cnt     <= RD_CNT0;
                        arready_q <= 1'b0;
                        r_state   <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        rvalid_q <= 1'b1;
                        r_state  <= R_RESP;
                        if (hit(r_addr)) begin
                            rdata_q <= mem[widx(r_addr)];
                            rresp_q <= OKAY;
                        end else begin
                            rdata_q <= 32'd0;
                            rresp_q <= DECERR;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (r_hs) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // AW and W are captured independently; the countdown starts once both are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_cnt     <= 4'd0;
            aw_addr   <= 32'd0;
            w_data    <= 32'd0;
            w_strb    <= 4'd0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr   <= bus.awaddr;
                        aw_got    <= 1'b1;
                        awready_q <= 1'b0;
                    end
                    if (w_hs) begin
                        w_data   <= bus.wdata;
                        w_strb   <= bus.wstrb;
                        w_got    <= 1'b1;
                        wready_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        w_cnt   <= WR_CNT0;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd0) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= hit(aw_addr) ? OKAY : DECERR;
                        w_state  <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        bvalid_q  <= 1'b0;
                        aw_got    <= 1'b0;
                        w_got     <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Storage is never reset; a reset edge only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    mem[widx(aw_addr)][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ysyx_23060191_axi_sram.md
YSYX_23060191_AXI_SRAM -- requirements
Module: ysyx_23060191_axi_sram

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words, power of two.
REQ-003 SHALL have parameter RD_LAT, default 1, range 1..15, read access delay in cycles.
REQ-004 SHALL have parameter WR_LAT, default 1, range 1..15, write access delay in cycles.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-007 SHALL have ports araddr in 32, arvalid in 1, arready out 1: read address channel.
REQ-008 SHALL have ports rdata out 32, rresp out 2, rvalid out 1, rready in 1: read data channel.
REQ-009 SHALL have ports awaddr in 32, awvalid in 1, awready out 1: write address channel.
REQ-010 SHALL have ports wdata in 32, wstrb in 4, wvalid in 1, wready out 1: write data channel.
REQ-011 SHALL have ports bresp out 2, bvalid out 1, bready in 1: write response channel.

Function
REQ-012 SHALL act as AXI4-Lite responder (one outstanding read plus one outstanding write) for the CPU fetch/load-store initiators.
REQ-013 SHALL treat a channel handshake as valid and ready both high at a rising edge.
REQ-014 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready = 1 only in R_IDLE.
REQ-015 On AR handshake SHALL latch araddr, go R_WAIT, and load a down-counter so rvalid rises exactly RD_LAT cycles after the handshake edge.
REQ-016 SHALL sample memory into rdata at the R_WAIT->R_RESP edge; rdata/rresp SHALL stay stable while rvalid = 1.
REQ-017 In R_RESP rvalid SHALL stay 1 until R handshake, then go R_IDLE; no new AR accepted in the handshake cycle.
REQ-018 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP; AW and W SHALL be accepted independently, in either order or the same cycle.
REQ-019 awready SHALL be 1 in W_IDLE until AW captured, then 0; wready likewise for W; both 0 in W_WAIT and W_RESP.
REQ-020 When both AW and W captured SHALL enter W_WAIT; the write SHALL commit at the edge entering W_RESP, WR_LAT cycles after the later of the two handshakes.
REQ-021 Commit SHALL update byte lane i only where wstrb[i] = 1; wstrb = 4'b0000 writes nothing but still responds OKAY.
REQ-022 In W_RESP bvalid SHALL stay 1 until B handshake, then go W_IDLE.
REQ-023 Word index SHALL be (addr - ADDR_BASE) >> 2; addr[1:0] ignored (word-aligned access).
REQ-024 Address outside [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS) SHALL give DECERR (2'b11): rdata = 0, no memory write; else resp OKAY (2'b00).
REQ-025 Read and write committing to the same word on the same edge: read SHALL return the old data.
REQ-026 Read and write channels SHALL proceed concurrently with no mutual stalling.
REQ-027 rdata/rresp/bresp values outside their valid phase SHALL hold last value (no X).

Reset
REQ-028 While rst = 1 at an edge: both FSMs to IDLE, counters 0, captured flags cleared; arready = awready = wready = 1, rvalid = bvalid = 0, rdata = 0, rresp = bresp = 2'b00 after that edge.
REQ-029 Reset mid-transaction SHALL discard it; a write not yet committed SHALL not modify memory; no response SHALL be issued for it.
REQ-030 Memory contents SHALL not be cleared by reset.

Verification
REQ-031 Write 0xDEADBEEF, wstrb 4'hF, to 0x8000_0010, then read it, RD_LAT = WR_LAT = 1 -> bresp 00; rvalid exactly 1 cycle after AR handshake, rdata 0xDEADBEEF, rresp 00.
REQ-032 W handshake 3 cycles before AW, wdata 0x11223344, wstrb 4'b0101, over prior 0xDEADBEEF -> read returns 0xDE22BE44; bvalid WR_LAT cycles after AW handshake.
REQ-033 Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH_WORDS = 1024) -> rresp 11, rdata 0; bresp 11; word 0 unchanged.
REQ-034 RD_LAT = 4, rready held low 5 cycles after rvalid -> rvalid high 4 cycles after handshake, rdata stable, arready low until R handshake.
REQ-035 Concurrent read and write of same word committing on same edge, old 0xA5A5A5A5, new 0x0 -> read 0xA5A5A5A5, following read 0x00000000.
REQ-036 rst pulsed in W_WAIT of write 0x12345678 to 0x8000_0020 -> no bvalid, word unchanged, awready = wready = 1 next cycle.
